// File: rtl/sram_model_hs_if.sv
// Request/response bundle between a slave-side bench master and the sram_model_hs memory model.
// The master drives requests and write data; the slave returns ready, read data and error strobes.
interface sram_model_hs_if #(
  parameter int N      = 16,
  parameter int BW     = 8,
  parameter int ADDR_W = 11
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [N-1:0]      be;
  logic [N*BW-1:0]   wdata;
  logic              ready;
  logic              rvalid;
  logic [N*BW-1:0]   rdata;
  logic              rerr;

  modport master (output req, we, addr, be, wdata, input ready, rvalid, rdata, rerr);
  modport slave  (input req, we, addr, be, wdata, output ready, rvalid, rdata, rerr);
endinterface

// File: rtl/sram_model_hs.sv
// Handshaked byte-lane SRAM model: pipelined reads with WS wait states, selectable
// read-during-write semantics, periodic backpressure and out-of-range read errors.
module sram_model_hs #(
  parameter int N            = 16,
  parameter int BW           = 8,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 11,
  parameter int WS           = 0,
  parameter int RDW_MODE     = 0,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_CYCLES = 1
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  sram_model_hs_if.slave bus
);
  localparam int W     = N * BW;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD + 1) : 1;
  localparam int SC_W  = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;

  localparam logic [ADDR_W:0]  DEPTH_A    = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic [SC_W-1:0]  STALL_LOAD = SC_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
  localparam bit               ADDR_OK    = (ADDR_W >= 31) || ((1 << ADDR_W) >= DEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_READY,
    S_STALL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  stall_q, stall_d;

  logic             ready;
  logic             accept;
  logic             in_range;
  logic             wr_fire;
  logic             rd_fire;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     rd_early;
  logic [W-1:0]     rd_late;
  logic [W-1:0]     rd_sel;

  // Read pipeline: stage 0 is loaded at the accept edge, stage WS feeds the output registers.
  logic              pv_q [WS+1];
  logic [ADDR_W-1:0] pa_q [WS+1];
  logic [W-1:0]      pd_q [WS+1];
  logic              pe_q [WS+1];

  logic              rvalid_q;
  logic              rerr_q;
  logic [W-1:0]      rdata_q;

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  assign ready    = (state_q == S_READY);
  assign accept   = bus.req && ready;
  assign in_range = ({1'b0, bus.addr} < DEPTH_A);
  assign wr_fire  = accept && bus.we && in_range;
  assign rd_fire  = accept && !bus.we;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the result depend on process order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    unique case (state_q)
      S_INIT:  state_d = S_READY;
      S_READY: begin
        if (accept && (STALL_PERIOD > 0)) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            stall_d = STALL_LOAD;
            state_d = S_STALL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_STALL: begin
        if (stall_q == '0) state_d = S_READY;
        else               stall_d = stall_q - SC_W'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: the array is intentionally outside the reset domain; contents survive
  // ARESETn and a reset loop over DEPTH words would not map onto a RAM.
  always_ff @(posedge ACLK) begin
    if (wr_fire) begin
      for (int i = 0; i < N; i++) begin
        if (bus.be[i]) mem_q[to_idx(bus.addr)][i*BW +: BW] <= bus.wdata[i*BW +: BW];
      end
    end
  end

  always_comb begin
    rd_early = '0;
    if (in_range) rd_early = mem_q[to_idx(bus.addr)];
  end

  // Late read sees every write accepted up to the edge before rvalid rises.
  always_comb begin
    rd_late = '0;
    if (!pe_q[WS]) rd_late = mem_q[to_idx(pa_q[WS])];
  end

  assign rd_sel = (RDW_MODE != 0) ? rd_late : pd_q[WS];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k <= WS; k++) begin
        pv_q[k] <= 1'b0;
        pa_q[k] <= '0;
        pd_q[k] <= '0;
        pe_q[k] <= 1'b0;
      end
    end else begin
      pv_q[0] <= rd_fire;
      pa_q[0] <= bus.addr;
      pd_q[0] <= rd_early;
      pe_q[0] <= !in_range;
      for (int k = 1; k <= WS; k++) begin
        pv_q[k] <= pv_q[k-1];
        pa_q[k] <= pa_q[k-1];
        pd_q[k] <= pd_q[k-1];
        pe_q[k] <= pe_q[k-1];
      end
    end
  end

  // rdata/rerr only move on an rvalid cycle and hold otherwise.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pv_q[WS];
      if (pv_q[WS]) begin
        rerr_q  <= pe_q[WS];
        rdata_q <= pe_q[WS] ? '0 : rd_sel;
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.rvalid = rvalid_q;
  assign bus.rerr   = rerr_q;
  assign bus.rdata  = rdata_q;

  a_addr_w_fits:  assert property (@(posedge ACLK) ADDR_OK);
  a_stall_cycles: assert property (@(posedge ACLK) STALL_CYCLES >= 1);
  a_no_x_ctrl:    assert property (@(posedge ACLK) disable iff (!ARESETn)
                                   !$isunknown({bus.req, bus.we}));
endmodule

// File: tb/tb_sram_model_hs.sv
// Directed bench for sram_model_hs: five instances (WS=0, WS=3, WS=2 in both RDW modes,
// 4/2 backpressure) driven from one shared request stream.
module tb_sram_model_hs;
  localparam int N     = 16;
  localparam int BW    = 8;
  localparam int W     = N * BW;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] P    = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [W-1:0] P2   = 128'h0F1E2D3C_4B5A6978_8796A5B4_FFFFFFFF;
  localparam logic [W-1:0] Q    = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [W-1:0] AA   = {16{8'hAA}};
  localparam logic [W-1:0] H55  = {16{8'h55}};
  localparam logic [W-1:0] M55  = 128'h55AAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [W-1:0] DA   = {16{8'hA1}};
  localparam logic [W-1:0] DB   = {16{8'hB2}};
  localparam logic [W-1:0] DC   = {16{8'hC3}};
  localparam logic [W-1:0] DD   = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

  logic          ACLK    = 1'b0;
  logic          ARESETn = 1'b0;
  logic          req     = 1'b0;
  logic          we      = 1'b0;
  logic [AW-1:0] addr    = '0;
  logic [N-1:0]  be      = '0;
  logic [W-1:0]  wdata   = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  sram_model_hs_if #(.N(N), .BW(BW), .ADDR_W(AW)) if_a ();
  sram_model_hs_if #(.N(N), .BW(BW), .ADDR_W(AW)) if_b ();
  sram_model_hs_if #(.N(N), .BW(BW), .ADDR_W(AW)) if_c ();
  sram_model_hs_if #(.N(N), .BW(BW), .ADDR_W(AW)) if_d ();
  sram_model_hs_if #(.N(N), .BW(BW), .ADDR_W(AW)) if_e ();

  assign if_a.req = req; assign if_a.we = we; assign if_a.addr = addr; assign if_a.be = be; assign if_a.wdata = wdata;
  assign if_b.req = req; assign if_b.we = we; assign if_b.addr = addr; assign if_b.be = be; assign if_b.wdata = wdata;
  assign if_c.req = req; assign if_c.we = we; assign if_c.addr = addr; assign if_c.be = be; assign if_c.wdata = wdata;
  assign if_d.req = req; assign if_d.we = we; assign if_d.addr = addr; assign if_d.be = be; assign if_d.wdata = wdata;
  assign if_e.req = req; assign if_e.we = we; assign if_e.addr = addr; assign if_e.be = be; assign if_e.wdata = wdata;

  sram_model_hs #(.N(N), .BW(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WS(0), .RDW_MODE(0),
                  .STALL_PERIOD(0), .STALL_CYCLES(1))
    dut_a (.ACLK(ACLK), .ARESETn(ARESETn), .bus(if_a));
  sram_model_hs #(.N(N), .BW(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WS(3), .RDW_MODE(0),
                  .STALL_PERIOD(0), .STALL_CYCLES(1))
    dut_b (.ACLK(ACLK), .ARESETn(ARESETn), .bus(if_b));
  sram_model_hs #(.N(N), .BW(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WS(2), .RDW_MODE(0),
                  .STALL_PERIOD(0), .STALL_CYCLES(1))
    dut_c (.ACLK(ACLK), .ARESETn(ARESETn), .bus(if_c));
  sram_model_hs #(.N(N), .BW(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WS(2), .RDW_MODE(1),
                  .STALL_PERIOD(0), .STALL_CYCLES(1))
    dut_d (.ACLK(ACLK), .ARESETn(ARESETn), .bus(if_d));
  sram_model_hs #(.N(N), .BW(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WS(0), .RDW_MODE(0),
                  .STALL_PERIOD(4), .STALL_CYCLES(2))
    dut_e (.ACLK(ACLK), .ARESETn(ARESETn), .bus(if_e));

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [N-1:0]  be;
    logic [W-1:0]  wdata;
    logic          exp_rv;
    logic [W-1:0]  exp_rd;
    logic          exp_re;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Called at a falling edge; the rising edge in between accepts the request.
  task automatic req_cycle(input logic w, input logic [AW-1:0] a, input logic [N-1:0] b,
                           input logic [W-1:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge ACLK);
  endtask

  task automatic idle_cycle();
    req = 1'b0; we = 1'b0;
    @(negedge ACLK);
  endtask

  function automatic logic [W-1:0] pat(input int k);
    return {N{8'(8'h10 + k)}};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic exp_rdy [14];
    logic seen_rv;

    vt[0]  = '{1'b1, 10'd5,    16'hFFFF, P,    1'b0, ZERO, 1'b0};
    vt[1]  = '{1'b0, 10'd5,    16'h0000, ZERO, 1'b1, P,    1'b0};
    vt[2]  = '{1'b1, 10'd5,    16'h000F, ONES, 1'b0, P,    1'b0};
    vt[3]  = '{1'b0, 10'd5,    16'h0000, ZERO, 1'b1, P2,   1'b0};
    vt[4]  = '{1'b1, 10'd5,    16'h0000, ZERO, 1'b0, P2,   1'b0};
    vt[5]  = '{1'b0, 10'd5,    16'h0000, ZERO, 1'b1, P2,   1'b0};
    vt[6]  = '{1'b0, 10'd1000, 16'h0000, ZERO, 1'b1, ZERO, 1'b1};
    vt[7]  = '{1'b1, 10'd1001, 16'hFFFF, ONES, 1'b0, ZERO, 1'b1};
    vt[8]  = '{1'b0, 10'd1001, 16'h0000, ZERO, 1'b1, ZERO, 1'b1};
    vt[9]  = '{1'b1, 10'd999,  16'hFFFF, Q,    1'b0, ZERO, 1'b1};
    vt[10] = '{1'b0, 10'd999,  16'h0000, ZERO, 1'b1, Q,    1'b0};
    vt[11] = '{1'b1, 10'd0,    16'hFFFF, AA,   1'b0, Q,    1'b0};
    vt[12] = '{1'b1, 10'd0,    16'h8000, H55,  1'b0, Q,    1'b0};
    vt[13] = '{1'b0, 10'd0,    16'h0000, ZERO, 1'b1, M55,  1'b0};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values, then first edge after release raises ready.
    @(negedge ACLK);
    @(negedge ACLK);
    check_bit("rst.ready", if_a.ready, 1'b0);
    check_bit("rst.rvalid", if_a.rvalid, 1'b0);
    check_bit("rst.rerr", if_a.rerr, 1'b0);
    check("rst.rdata", if_a.rdata, ZERO);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_bit("rel.ready_a", if_a.ready, 1'b1);
    check_bit("rel.ready_e", if_e.ready, 1'b1);

    // WS=0 single requests: one accept, one idle, then look at the response cycle.
    for (int i = 0; i < 14; i++) begin
      req_cycle(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata);
      idle_cycle();
      check_bit($sformatf("vec%0d.rvalid", i), if_a.rvalid, vt[i].exp_rv);
      check($sformatf("vec%0d.rdata", i), if_a.rdata, vt[i].exp_rd);
      check_bit($sformatf("vec%0d.rerr", i), if_a.rerr, vt[i].exp_re);
    end

    // WS=3: eight back-to-back reads return on cycles 4..11 after the first accept.
    for (int k = 0; k < 8; k++) req_cycle(1'b1, AW'(k), 16'hFFFF, pat(k));
    req_cycle(1'b0, 10'd0, 16'h0000, ZERO);
    check_bit("b2b.c0.rvalid", if_b.rvalid, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c < 8) req_cycle(1'b0, AW'(c), 16'h0000, ZERO);
      else       idle_cycle();
      check_bit($sformatf("b2b.c%0d.rvalid", c), if_b.rvalid, (c >= 4) && (c <= 11));
      if ((c >= 4) && (c <= 11))
        check($sformatf("b2b.c%0d.rdata", c), if_b.rdata, pat(c - 4));
    end

    // Read-during-write, WS=2: write one cycle after the read accept.
    req_cycle(1'b1, 10'd9, 16'hFFFF, DA);
    req_cycle(1'b0, 10'd9, 16'h0000, ZERO);
    req_cycle(1'b1, 10'd9, 16'hFFFF, DB);
    idle_cycle();
    check_bit("rdw1.c2.rvalid_m0", if_c.rvalid, 1'b0);
    check_bit("rdw1.c2.rvalid_m1", if_d.rvalid, 1'b0);
    idle_cycle();
    check_bit("rdw1.c3.rvalid_m0", if_c.rvalid, 1'b1);
    check_bit("rdw1.c3.rvalid_m1", if_d.rvalid, 1'b1);
    check("rdw1.rdata_m0", if_c.rdata, DA);
    check("rdw1.rdata_m1", if_d.rdata, DB);

    // Write accepted on the cycle just before rvalid is still visible in mode 1.
    req_cycle(1'b0, 10'd9, 16'h0000, ZERO);
    idle_cycle();
    req_cycle(1'b1, 10'd9, 16'hFFFF, DC);
    check_bit("rdw2.c2.rvalid_m1", if_d.rvalid, 1'b0);
    idle_cycle();
    check_bit("rdw2.c3.rvalid_m1", if_d.rvalid, 1'b1);
    check("rdw2.rdata_m0", if_c.rdata, DB);
    check("rdw2.rdata_m1", if_d.rdata, DC);

    // Reset with two reads in flight, then a held request stream against the 4/2 staller.
    req_cycle(1'b1, 10'd20, 16'hFFFF, DD);
    req_cycle(1'b1, 10'd21, 16'hFFFF, ~DD);
    req_cycle(1'b0, 10'd20, 16'h0000, ZERO);
    req_cycle(1'b0, 10'd21, 16'h0000, ZERO);
    req = 1'b0;
    ARESETn = 1'b0;
    #1;
    check_bit("mid.rst.rvalid_a", if_a.rvalid, 1'b0);
    check_bit("mid.rst.ready_e", if_e.ready, 1'b0);
    @(negedge ACLK);
    check_bit("mid.rst.rvalid_b", if_b.rvalid, 1'b0);
    ARESETn = 1'b1;
    req = 1'b1; we = 1'b1; addr = 10'd1001; be = 16'hFFFF; wdata = ONES;
    seen_rv = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge ACLK);
      check_bit($sformatf("stall.r%0d.ready", k), if_e.ready, exp_rdy[k-1]);
      seen_rv = seen_rv | if_a.rvalid | if_b.rvalid | if_c.rvalid | if_d.rvalid;
    end
    check_bit("mid.no_rvalid_after_release", seen_rv, 1'b0);
    idle_cycle();

    // Array contents survive reset.
    req_cycle(1'b0, 10'd20, 16'h0000, ZERO);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    check_bit("keep.c3.rvalid", if_b.rvalid, 1'b0);
    idle_cycle();
    check_bit("keep.c4.rvalid", if_b.rvalid, 1'b1);
    check("keep.rdata", if_b.rdata, DD);
    check_bit("keep.rerr", if_b.rerr, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_model_hs.md
Name: sram_model_hs

Overview:
- Parametrised, handshaked, byte-lane SRAM behavioural model for slave-side benches.
- Successor to the fixed 16-lane memory model: generic lane count/width, pipelined read latency with valid, selectable read-during-write semantics, programmable backpressure, out-of-range error.
- Sits behind the ASI user-side port; bench-only, not synthesised.

Parameters:
N, 16, number of byte lanes
BW, 8, bits per lane
DEPTH, 1024, number of words (need not be power of two)
ADDR_W, 11, word-address width; must satisfy 2**ADDR_W >= DEPTH
WS, 0, read wait states; read latency = WS+1 cycles
RDW_MODE, 0, 0 = read samples array at accept (old data); 1 = samples at output stage (sees later writes)
STALL_PERIOD, 0, accepted requests between stalls; 0 = never stall
STALL_CYCLES, 1, cycles ready is held low per stall (>=1)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req  in  1  request valid
we  in  1  1 = write, 0 = read
addr  in  ADDR_W  word address
be  in  N  byte enables (writes only)
wdata  in  N*BW  write data, lane i = bits [i*BW +: BW]
ready  out  1  request accepted when req && ready
rvalid  out  1  one-cycle read-data strobe
rdata  out  N*BW  read data
rerr  out  1  with rvalid: read address out of range

Behaviour:
- Reset (async assert, sync release): ready=0, rvalid=0, rerr=0, rdata=0, stall/request counters=0, pipeline valids cleared. Array contents NOT reset, retained across reset. First ACLK edge after release: ready=1.
- Accept: posedge with req && ready. No accept while ready=0; inputs ignored.
- Write accept, addr<DEPTH: each lane i with be[i]=1 updated at that edge; other lanes unchanged. be=0 is a legal no-op. addr>=DEPTH: write dropped, no response.
- Read accept: enters pipeline of WS+1 registered stages carrying valid, addr, data, err. rvalid asserts exactly WS+1 cycles after the accept edge, one cycle per read. Fully pipelined: back-to-back reads give back-to-back rvalid, in order.
- rdata/rerr update only on rvalid cycles; otherwise hold last value.
- RDW_MODE=0: data captured from array at accept edge (pre-write value at that address).
- RDW_MODE=1: data read from array using stored addr at the final stage; any write accepted up to and including the cycle before rvalid is visible.
- Out-of-range read (addr>=DEPTH): rdata=0, rerr=1 on its rvalid; no array access.
- Backpressure (STALL_PERIOD>0): counter increments per accept (read or write). On the accept that makes count==STALL_PERIOD, count clears and ready drops for the next STALL_CYCLES cycles, then returns to 1. In-flight reads continue draining during stall.
- STALL_PERIOD=0: ready constantly 1 after reset.
- Reset mid-operation: in-flight reads discarded (no rvalid), stall aborted, counters cleared.
- Assertions: 2**ADDR_W>=DEPTH; STALL_CYCLES>=1; no X on req/we when ARESETn=1.

Test Plan:
- N=16, WS=0: write addr 5, be=16'hFFFF, data=pattern P; read addr 5 -> rvalid 1 cycle after accept, rdata=P, rerr=0.
- Partial write: write addr 5 be=16'h000F data=all-1s over P -> read returns P with lanes 0-3 = 8'hFF, lanes 4-15 unchanged.
- WS=3, 8 back-to-back reads addr 0..7 -> rvalid on cycles 4..11 after first accept, in order, data matching prior writes.
- WS=2, read addr 9 (old=A) then write addr 9 data=B next cycle: RDW_MODE=0 -> rdata=A; RDW_MODE=1 -> rdata=B.
- DEPTH=1000, ADDR_W=10: read addr 1000 -> rvalid, rerr=1, rdata=0; write addr 1001 then read 1001 -> still rerr=1.
- STALL_PERIOD=4, STALL_CYCLES=2, req held high -> ready low 2 cycles after every 4th accept; reset asserted with 2 reads in flight (WS=3) -> no rvalid after release, array data preserved.
